data_mem_resp: RTL and testbench

Data-memory responder on the core's load/store bus: accepts the single-cycle `rdEn`/`wrEn` requests issued by `rv32i_core`, performs byte/half/word stores with lane enables, and returns aligned, sign- or zero-extended load data exactly two cycles after the request, which is when the core's write-back stage samples `dataBusIn`. It decodes its own address window and flags misaligned, out-of-window and malformed accesses. The backing store is a synchronous word-wide RAM array internal to the block.

---
 rtl/data_mem_resp.sv | 101 ++++++++++
 tb/tb_data_mem_resp.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/data_mem_resp.sv
// Data-memory responder: lane-enabled stores, and loads returned two cycles after
// the request with alignment and sign/zero extension; flags rejected accesses.
module data_mem_resp #(
  parameter int          ADDR_W    = 12,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rstB,
  input  logic [31:0] addr,
  input  logic [31:0] dataBusOut,
  input  logic        wrEn,
  input  logic        rdEn,
  input  logic [3:0]  RamMode,
  output logic [31:0] dataBusIn,
  output logic        dataBusInEn,
  output logic        busErr
);
  localparam int DEPTH = 1 << ADDR_W;

  logic              m_b, m_h, m_w;
  logic              hit, legal, mis, rej, st_ok;
  logic [ADDR_W-1:0] idx;
  logic [3:0]        lane_we;
  logic [31:0]       wdata;

  logic [3:0][7:0]   mem_q [DEPTH];
  logic [3:0][7:0]   rdata_q;
  logic [2:1]        vld_pipe_q;
  logic [1:0]        ld_off_q;
  logic [2:0]        ld_mode_q;   // {byte, half, unsigned}
  logic              ld_err_q;
  logic [31:0]       ext_d, dataBusIn_q;
  logic              busErr_q;

  assign m_b   = RamMode[3];
  assign m_h   = RamMode[2];
  assign m_w   = RamMode[1];
  assign idx   = addr[ADDR_W+1:2];
  assign hit   = (addr[31:ADDR_W+2] == BASE_ADDR[31:ADDR_W+2]);
  assign legal = ({m_b, m_h, m_w} == 3'b100) || ({m_b, m_h, m_w} == 3'b010) ||
                 ({m_b, m_h, m_w} == 3'b001);
  assign mis   = (m_h && addr[0]) || (m_w && (addr[1:0] != 2'b00));
  assign rej   = !hit || !legal || mis || (wrEn && rdEn);
  // A store in the reset cycle must not land in the array.
  assign st_ok = wrEn && !rej && rstB;

  always_comb begin
    lane_we = 4'b0000;
    wdata   = dataBusOut;
    if (m_b) begin
      lane_we[addr[1:0]] = 1'b1;
      wdata              = {4{dataBusOut[7:0]}};
    end else if (m_h) begin
      lane_we = addr[1] ? 4'b1100 : 4'b0011;
      wdata   = {2{dataBusOut[15:0]}};
    end else begin
      lane_we = 4'b1111;
    end
  end

  // Array is never reset; write at the request edge, read at the same edge.
  always_ff @(posedge clk) begin
    if (st_ok)
      for (int l = 0; l < 4; l++)
        if (lane_we[l]) mem_q[idx][l] <= wdata[l*8 +: 8];
    if (rdEn) rdata_q <= mem_q[idx];
  end

  always_ff @(posedge clk) begin
    if (!rstB) begin
      vld_pipe_q  <= '0;
      ld_off_q    <= '0;
      ld_mode_q   <= '0;
      ld_err_q    <= 1'b0;
      dataBusIn_q <= '0;
      busErr_q    <= 1'b0;
    end else begin
      vld_pipe_q <= {vld_pipe_q[1], rdEn};
      ld_off_q   <= addr[1:0];
      ld_mode_q  <= {m_b, m_h, RamMode[0]};
      ld_err_q   <= rej;
      // Store errors surface one cycle after the request, load errors with the data.
      busErr_q   <= (wrEn && rej) || (vld_pipe_q[1] && ld_err_q);
      if (vld_pipe_q[1]) dataBusIn_q <= ld_err_q ? 32'h0 : ext_d;
    end
  end

  always_comb begin
    ext_d = rdata_q;
    if (ld_mode_q[2])
      ext_d = {{24{!ld_mode_q[0] && rdata_q[ld_off_q][7]}}, rdata_q[ld_off_q]};
    else if (ld_mode_q[1])
      ext_d = ld_off_q[1] ?
              {{16{!ld_mode_q[0] && rdata_q[3][7]}}, rdata_q[3], rdata_q[2]} :
              {{16{!ld_mode_q[0] && rdata_q[1][7]}}, rdata_q[1], rdata_q[0]};
  end

  assign dataBusIn   = dataBusIn_q;
  assign dataBusInEn = vld_pipe_q[2];
  assign busErr      = busErr_q;
endmodule

// File: tb/tb_data_mem_resp.sv
// Bench for data_mem_resp: directed vector table, then random traffic against a
// byte-addressed reference model with a one-entry load delay line.
module tb_data_mem_resp;
  localparam int          ADDR_W = 12;
  localparam logic [31:0] BASE   = 32'h0000_0000;

  logic        clk = 1'b0, rstB = 1'b0, wrEn = 1'b0, rdEn = 1'b0;
  logic [31:0] addr = '0, dataBusOut = '0, dataBusIn;
  logic [3:0]  RamMode = 4'b0010;
  logic        dataBusInEn, busErr;

  data_mem_resp #(.ADDR_W(ADDR_W), .BASE_ADDR(BASE)) dut (
    .clk(clk), .rstB(rstB), .addr(addr), .dataBusOut(dataBusOut), .wrEn(wrEn),
    .rdEn(rdEn), .RamMode(RamMode), .dataBusIn(dataBusIn),
    .dataBusInEn(dataBusInEn), .busErr(busErr));

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0;

  // Reference model: bytes 0..63 of the window, the previous cycle's load, held data.
  logic [7:0]  mm [64];
  logic        p_v = 1'b0, p_err = 1'b0;
  logic [31:0] p_val = '0, m_dat = '0;
  logic        e_en, e_err;

  typedef struct {
    logic rst, wr, rd;
    logic [3:0] md;
    logic [31:0] a, wd;
    logic en, err;
    logic [31:0] dat;
  } vec_t;
  vec_t tbl[$];

  function automatic logic [3:0] fm(input int f3);
    logic [2:0] f;
    f = 3'(f3);
    return {f[1:0] == 2'd0, f[1:0] == 2'd1, f[1:0] == 2'd2, f[2]};
  endfunction

  function automatic vec_t v(input logic rst, wr, rd, input logic [3:0] md,
                             input logic [31:0] a, wd, input logic en, err,
                             input logic [31:0] dat);
    vec_t r;
    r.rst = rst; r.wr = wr; r.rd = rd; r.md = md; r.a = a; r.wd = wd;
    r.en = en; r.err = err; r.dat = dat;
    return r;
  endfunction

  function automatic logic rejected(input logic [31:0] a, input logic [3:0] md,
                                    input logic wr, rd);
    logic miss, bad, mis;
    miss = (a >> (ADDR_W + 2)) != (BASE >> (ADDR_W + 2));
    bad  = $countones(md[3:1]) != 1;
    mis  = (md[2] && a[0]) || (md[1] && (a % 4 != 0));
    return miss || bad || mis || (wr && rd);
  endfunction

  function automatic logic [31:0] mload(input logic [31:0] a, input logic [3:0] md);
    int b;
    logic [15:0] h;
    b = int'(a[5:0]);
    if (md[3]) return md[0] ? {24'h0, mm[b]} : {{24{mm[b][7]}}, mm[b]};
    if (md[2]) begin
      h = {mm[b + 1], mm[b]};
      return md[0] ? {16'h0, h} : {{16{h[15]}}, h};
    end
    return {mm[b + 3], mm[b + 2], mm[b + 1], mm[b]};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  // One request cycle; outputs are checked #1 after the edge that ends it.
  task automatic step(input logic rst, wr, rd, input logic [3:0] md,
                      input logic [31:0] a, wd);
    logic rj;
    int b;
    @(negedge clk);
    rstB = rst; wrEn = wr; rdEn = rd; RamMode = md; addr = a; dataBusOut = wd;
    rj = rejected(a, md, wr, rd);
    if (!rst) begin
      e_en = 1'b0; e_err = 1'b0; m_dat = '0; p_v = 1'b0;
    end else begin
      e_en  = p_v;
      e_err = (p_v && p_err) || (wr && rj);
      if (p_v) m_dat = p_val;
      p_v   = rd;
      p_err = rj;
      p_val = (rd && !rj) ? mload(a, md) : 32'h0;
      if (wr && !rj) begin
        b = int'(a[5:0]);
        mm[b] = wd[7:0];
        if (md[2] || md[1]) mm[b + 1] = wd[15:8];
        if (md[1]) begin mm[b + 2] = wd[23:16]; mm[b + 3] = wd[31:24]; end
      end
    end
    @(posedge clk);
    #1;
    chk("model_en",   {31'h0, dataBusInEn}, {31'h0, e_en});
    chk("model_err",  {31'h0, busErr},      {31'h0, e_err});
    chk("model_data", dataBusIn,            m_dat);
  endtask

  initial begin
    logic [3:0] MB, MBU, MH, MHU, MW, M0;
    MB = fm(0); MBU = fm(4); MH = fm(1); MHU = fm(5); MW = fm(2); M0 = '0;
    for (int i = 0; i < 64; i++) mm[i] = '0;

    step(0, 0, 0, MW, 0, 0);
    step(0, 0, 0, MW, 0, 0);
    chk("reset_en",   {31'h0, dataBusInEn}, 32'h0);
    chk("reset_err",  {31'h0, busErr},      32'h0);
    chk("reset_data", dataBusIn,            32'h0);
    for (int w = 0; w < 16; w++) step(1, 1, 0, MW, 32'(w * 4), $urandom);
    step(0, 0, 0, MW, 0, 0);

    // Expected fields are the outputs after this row's edge.
    tbl.push_back(v(1, 1, 0, MW,  32'h10, 32'hDEADBEEF, 0, 0, 32'h0));
    tbl.push_back(v(1, 0, 1, MW,  32'h10, 0,            0, 0, 32'h0));
    tbl.push_back(v(1, 1, 0, MB,  32'h13, 32'h80,       1, 0, 32'hDEADBEEF));
    tbl.push_back(v(1, 0, 1, MB,  32'h13, 0,            0, 0, 32'hDEADBEEF));
    tbl.push_back(v(1, 0, 1, MBU, 32'h13, 0,            1, 0, 32'hFFFFFF80));
    tbl.push_back(v(1, 0, 1, MW,  32'h10, 0,            1, 0, 32'h00000080));
    tbl.push_back(v(1, 1, 0, MH,  32'h12, 32'h8001,     1, 0, 32'h80ADBEEF));
    tbl.push_back(v(1, 0, 1, MH,  32'h12, 0,            0, 0, 32'h80ADBEEF));
    tbl.push_back(v(1, 0, 1, MHU, 32'h12, 0,            1, 0, 32'hFFFF8001));
    tbl.push_back(v(1, 0, 1, MH,  32'h10, 0,            1, 0, 32'h00008001));
    tbl.push_back(v(1, 0, 1, MW,  32'h11, 0,            1, 0, 32'hFFFFBEEF));
    tbl.push_back(v(1, 0, 0, M0,  0,      0,            1, 1, 32'h0));
    tbl.push_back(v(1, 1, 0, MH,  32'h13, 32'h1234,     0, 1, 32'h0));
    tbl.push_back(v(1, 0, 1, MW,  32'h10000, 0,         0, 0, 32'h0));
    tbl.push_back(v(1, 0, 0, M0,  0,      0,            1, 1, 32'h0));
    tbl.push_back(v(1, 0, 1, MW,  32'h10, 0,            0, 0, 32'h0));
    tbl.push_back(v(1, 0, 0, M0,  0,      0,            1, 0, 32'h8001BEEF));
    tbl.push_back(v(1, 1, 0, MW,  32'h0,  32'h11111111, 0, 0, 32'h8001BEEF));
    tbl.push_back(v(1, 1, 0, MW,  32'h4,  32'h22222222, 0, 0, 32'h8001BEEF));
    tbl.push_back(v(1, 1, 0, MW,  32'h8,  32'h33333333, 0, 0, 32'h8001BEEF));
    tbl.push_back(v(1, 0, 1, MW,  32'h0,  0,            0, 0, 32'h8001BEEF));
    tbl.push_back(v(1, 0, 1, MW,  32'h4,  0,            1, 0, 32'h11111111));
    tbl.push_back(v(1, 0, 1, MW,  32'h8,  0,            1, 0, 32'h22222222));
    tbl.push_back(v(1, 0, 0, M0,  0,      0,            1, 0, 32'h33333333));
    tbl.push_back(v(1, 0, 0, M0,  0,      0,            0, 0, 32'h33333333));
    // Reset with two loads in flight, then a store in a reset cycle.
    tbl.push_back(v(1, 0, 1, MW,  32'h0,  0,            0, 0, 32'h33333333));
    tbl.push_back(v(0, 0, 1, MW,  32'h4,  0,            0, 0, 32'h0));
    tbl.push_back(v(1, 0, 0, M0,  0,      0,            0, 0, 32'h0));
    tbl.push_back(v(1, 0, 0, M0,  0,      0,            0, 0, 32'h0));
    tbl.push_back(v(0, 1, 0, MW,  32'h0,  32'hAAAAAAAA, 0, 0, 32'h0));
    tbl.push_back(v(1, 0, 1, MW,  32'h0,  0,            0, 0, 32'h0));
    tbl.push_back(v(1, 0, 0, M0,  0,      0,            1, 0, 32'h11111111));

    foreach (tbl[i]) begin
      step(tbl[i].rst, tbl[i].wr, tbl[i].rd, tbl[i].md, tbl[i].a, tbl[i].wd);
      chk($sformatf("vec%0d_en", i),  {31'h0, dataBusInEn}, {31'h0, tbl[i].en});
      chk($sformatf("vec%0d_err", i), {31'h0, busErr},      {31'h0, tbl[i].err});
      chk($sformatf("vec%0d_data", i), dataBusIn,           tbl[i].dat);
    end

    for (int n = 0; n < 600; n++) begin
      logic [31:0] a;
      logic [3:0]  md;
      int r;
      a  = 32'($urandom_range(0, 63));
      if ($urandom_range(0, 9) == 0) a = a | (32'h1 << $urandom_range(ADDR_W + 2, 31));
      md = ($urandom_range(0, 15) == 0) ? 4'($urandom) : fm($urandom_range(0, 7));
      r  = $urandom_range(0, 9);
      step($urandom_range(0, 49) != 0, r inside {[4:7]}, r inside {[0:3], 7}, md, a,
           $urandom);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
